// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD seconds countdown timer (99..00).
// An internal prescaler divides the board clock down to a one-second tick
// while running; the registered digit outputs always hold valid BCD codes
// so they can feed seven-segment decoders directly.
module bcd_countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Prescaler value on which the one-second tick fires.
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);

    state_t           state_q, state_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;

    logic             tick;
    logic             value_zero;
    logic             value_one;

    // Out-of-range load digits saturate to 9 so the display never sees
    // a non-BCD code.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign tick       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    assign value_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign value_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

    // State register and all registered outputs; reset is synchronous, active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: load beats start, start beats pause; counting in
    // RUN proceeds on the same edge as a pause so a tick is never lost.
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        presc_d   = presc_q;
        timeout_d = 1'b0;

        if (load) begin
            tens_d  = clamp_bcd(load_tens);
            ones_d  = clamp_bcd(load_ones);
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            // Prescaler and digit decrement while running.
            if (state_q == ST_RUN) begin
                if (tick) begin
                    presc_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if (value_one) begin
                        state_d   = ST_EXPIRED;
                        timeout_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end

            // Control strobes; start masks pause in the same cycle.
            if (start) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!value_zero) begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end
                    end
                    ST_PAUSED: begin
                        // Resume keeps the partial second already counted.
                        state_d = ST_RUN;
                    end
                    default: begin
                        // RUN and EXPIRED ignore start.
                    end
                endcase
            end else if (pause) begin
                // A pause on the expiry edge leaves the timer expired.
                if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
                    state_d = ST_PAUSED;
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios with expected values taken
// from the timer's behaviour description, then a randomized run compared
// cycle by cycle against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining seconds as a plain integer plus a mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
    int m_secs    = 0;
    int m_mode    = M_IDLE;
    int m_partial = 0;
    bit m_timeout = 1'b0;

    bcd_countdown_timer #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int old_mode;
        old_mode  = m_mode;
        m_timeout = 1'b0;
        if (!rst) begin
            m_secs = 0; m_mode = M_IDLE; m_partial = 0;
        end else if (load) begin
            m_secs    = clampd(load_tens) * 10 + clampd(load_ones);
            m_mode    = M_IDLE;
            m_partial = 0;
        end else begin
            if (old_mode == M_RUN) begin
                m_partial++;
                if (m_partial == TPS) begin
                    m_partial = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_mode    = M_EXPIRED;
                        m_timeout = 1'b1;
                    end
                end
            end
            if (start) begin
                if (old_mode == M_IDLE && m_secs != 0) begin
                    m_mode = M_RUN; m_partial = 0;
                end else if (old_mode == M_PAUSED) begin
                    m_mode = M_RUN;
                end
            end else if (pause && old_mode == M_RUN && m_mode == M_RUN) begin
                m_mode = M_PAUSED;
            end
        end
    endtask

    // One clock edge; outputs are settled #1 after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_strobes();
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; load_tens = t; load_ones = o;
        step();
        clear_strobes();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        clear_strobes();
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b1; load_tens = 4'd5; load_ones = 4'd5; start = 1'b1;
        step(); step();
        total++;
        if ({tens, ones, running, timeout} !== 10'h000) begin
            bad++;
            $display("FAIL reset: tens=%0d ones=%0d run=%0b to=%0b, want 0 0 0 0",
                     tens, ones, running, timeout);
        end
        clear_strobes();
        rst = 1'b1;
        step();
        total++;
        if ({tens, ones, running} !== 9'h000) begin
            bad++;
            $display("FAIL reset_idle: tens=%0d ones=%0d run=%0b, want 0 0 0", tens, ones, running);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_count();
        int exp_vals[3] = '{11, 10, 9};
        do_load(4'd1, 4'd2);
        do_start();
        total++;
        if (running !== 1'b1 || tens !== 4'd1 || ones !== 4'd2) begin
            bad++;
            $display("FAIL start_run: run=%0b val=%0d%0d, want 1 12", running, tens, ones);
        end
        for (int s = 0; s < 3; s++) begin
            for (int e = 1; e < TPS; e++) step();
            total++;
            if (tens * 10 + ones == exp_vals[s]) begin
                bad++;
                $display("FAIL early_dec%0d: val=%0d%0d before tick", s, tens, ones);
            end
            step();
            total++;
            if (int'(tens) * 10 + int'(ones) != exp_vals[s]) begin
                bad++;
                $display("FAIL count%0d: val=%0d%0d, want %0d", s, tens, ones, exp_vals[s]);
            end
        end
        $display("test_basic_count done");
    endtask

    task automatic test_expiry();
        do_load(4'd0, 4'd2);
        do_start();
        for (int e = 0; e < TPS; e++) step();
        total++;
        if (tens !== 4'd0 || ones !== 4'd1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL at_01: val=%0d%0d to=%0b, want 01 0", tens, ones, timeout);
        end
        for (int e = 0; e < TPS; e++) step();
        total++;
        if (tens !== 4'd0 || ones !== 4'd0 || timeout !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL expire: val=%0d%0d to=%0b run=%0b, want 00 1 0",
                     tens, ones, timeout, running);
        end
        step();
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: to=%0b, want 0", timeout);
        end
        do_start();
        for (int e = 0; e < 2 * TPS; e++) begin
            total++;
            if (timeout !== 1'b0 || running !== 1'b0 || {tens, ones} !== 8'h00) begin
                bad++;
                $display("FAIL expired_hold: val=%0d%0d to=%0b run=%0b", tens, ones, timeout, running);
            end
            step();
        end
        $display("test_expiry done");
    endtask

    task automatic test_pause_resume();
        do_load(4'd0, 4'd5);
        do_start();
        step();
        pause = 1'b1;
        step();
        clear_strobes();
        for (int e = 0; e < 10; e++) step();
        total++;
        if (tens !== 4'd0 || ones !== 4'd5 || running !== 1'b0) begin
            bad++;
            $display("FAIL paused: val=%0d%0d run=%0b, want 05 0", tens, ones, running);
        end
        do_start();
        step();
        total++;
        if (ones !== 4'd5 || running !== 1'b1) begin
            bad++;
            $display("FAIL resume1: ones=%0d run=%0b, want 5 1", ones, running);
        end
        step();
        total++;
        if (tens !== 4'd0 || ones !== 4'd4) begin
            bad++;
            $display("FAIL resume_tick: val=%0d%0d, want 04", tens, ones);
        end
        $display("test_pause_resume done");
    endtask

    task automatic test_priority_clamp();
        load = 1'b1; load_tens = 4'hA; load_ones = 4'hF; start = 1'b1;
        step();
        clear_strobes();
        step();
        total++;
        if (tens !== 4'd9 || ones !== 4'd9 || running !== 1'b0) begin
            bad++;
            $display("FAIL clamp_prio: val=%0d%0d run=%0b, want 99 0", tens, ones, running);
        end
        do_load(4'd0, 4'd0);
        do_start();
        step();
        total++;
        if (running !== 1'b0 || {tens, ones} !== 8'h00) begin
            bad++;
            $display("FAIL start_at_00: val=%0d%0d run=%0b, want 00 0", tens, ones, running);
        end
        // Load arriving on what would be the expiry edge.
        do_load(4'd0, 4'd1);
        do_start();
        for (int e = 1; e < TPS; e++) step();
        load = 1'b1; load_tens = 4'd0; load_ones = 4'd3;
        step();
        clear_strobes();
        total++;
        if (timeout !== 1'b0 || ones !== 4'd3 || running !== 1'b0) begin
            bad++;
            $display("FAIL load_on_expiry: val=%0d%0d to=%0b run=%0b, want 03 0 0",
                     tens, ones, timeout, running);
        end
        $display("test_priority_clamp done");
    endtask

    task automatic test_reset_midcount();
        do_load(4'd3, 4'd8);
        do_start();
        for (int e = 0; e < TPS; e++) step();
        total++;
        if (tens !== 4'd3 || ones !== 4'd7 || running !== 1'b1) begin
            bad++;
            $display("FAIL at_37: val=%0d%0d run=%0b, want 37 1", tens, ones, running);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++;
        if ({tens, ones, running, timeout} !== 10'h000) begin
            bad++;
            $display("FAIL mid_reset: val=%0d%0d run=%0b to=%0b, want 00 0 0",
                     tens, ones, running, timeout);
        end
        for (int e = 0; e < 2 * TPS; e++) begin
            step();
            total++;
            if (timeout !== 1'b0 || running !== 1'b0) begin
                bad++;
                $display("FAIL post_reset: to=%0b run=%0b, want 0 0", timeout, running);
            end
        end
        $display("test_reset_midcount done");
    endtask

    task automatic test_random();
        int exp_t, exp_o, errs;
        errs = 0;
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            load      = ($urandom_range(0, 39) == 0);
            load_tens = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
            load_ones = 4'($urandom_range(0, 15));
            start     = ($urandom_range(0, 9) == 0);
            pause     = ($urandom_range(0, 14) == 0);
            step();
            exp_t = m_secs / 10;
            exp_o = m_secs % 10;
            total++;
            if (int'(tens) != exp_t || int'(ones) != exp_o || running !== (m_mode == M_RUN)
                || timeout !== m_timeout) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random c=%0d: val=%0d%0d run=%0b to=%0b, want %0d%0d %0b %0b",
                             c, tens, ones, running, timeout, exp_t, exp_o,
                             (m_mode == M_RUN), m_timeout);
            end
        end
        clear_strobes();
        rst = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_expiry();
        test_pause_resume();
        test_priority_clamp();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Two-digit BCD seconds countdown timer (99..00) for the game display path. It loads a starting value, decrements once per second while running, and flags expiry. Its tens/ones outputs drive the two BCD-to-seven-segment decoder instances directly, so every output digit is always a valid BCD code 0-9. It runs on the single board clock with an internal prescaler that generates the 1 s tick.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per one-second tick (minimum 2; benches use 4)
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= TICKS_PER_SEC

Ports:
clk        input   1  system clock; all logic on the rising edge
rst        input   1  synchronous, active-low reset
load       input   1  one-cycle strobe; captures load_tens/load_ones
load_tens  input   4  BCD tens digit to load
load_ones  input   4  BCD ones digit to load
start      input   1  one-cycle strobe; begin or resume counting
pause      input   1  one-cycle strobe; suspend counting
tens       output  4  current tens digit, BCD, registered
ones       output  4  current ones digit, BCD, registered
running    output  1  high while in RUN, registered
timeout    output  1  one-cycle pulse on expiry, registered

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-low, sampled only on the rising edge of clk.
- Reset (rst=0 at an edge) forces state=IDLE, tens=0, ones=0, running=0, timeout=0, prescaler=0. Reset overrides all other inputs, including mid-count.
- States:
  - IDLE: loaded or reset value held.
  - RUN: counting.
  - PAUSED: value and prescaler frozen.
  - EXPIRED: holds 00.
- Input priority in the same cycle: load > start > pause.
- load, in any state: tens/ones <= loaded digits, prescaler <= 0, state <= IDLE, running <= 0. A load digit >9 is clamped to 9 (e.g. load_tens=4'hC loads 9).
- start:
  - IDLE with value != 00: state <= RUN, prescaler <= 0.
  - IDLE with value 00: ignored.
  - PAUSED: state <= RUN, prescaler retained (no restart of the partial second).
  - RUN or EXPIRED: ignored.
- pause:
  - RUN: state <= PAUSED.
  - Any other state: ignored.
- Prescaler (RUN only):
  - Increments each cycle.
  - When it equals TICKS_PER_SEC-1, it wraps to 0 and a tick occurs on that edge.
  - First decrement happens TICKS_PER_SEC edges after the start edge.
- Decrement on tick:
  - ones>0: ones-1.
  - Else: ones <= 9, tens <= tens-1.
  - Digits never leave 0-9.
- Expiry: when the tick takes the value from 01 to 00, on the same edge:
  - state <= EXPIRED, running <= 0, timeout <= 1.
  - timeout returns to 0 on the next edge.
- EXPIRED holds 00 until load or reset. timeout never re-pulses without a new load+start.
- Simultaneous events:
  - pause on the tick edge: the decrement still applies, then PAUSED.
  - load on the expiry edge: load wins; no timeout pulse.
- running == (state==RUN), registered with the state.

Test Plan:
1. Reset: hold rst=0 two cycles with load/start asserted -> tens=0, ones=0, running=0, timeout=0, state IDLE.
2. Basic count, TICKS_PER_SEC=4: load 1/2, start -> running=1; 12->11 after 4 edges; 11->10 at 8 edges; 10->09 at 12 edges (borrow).
3. Expiry: load 0/2, start -> 02,01,00 at edges 4,8. timeout=1 exactly on the cycle 00 appears, then 0. running=0; a later start leaves 00 with no pulse.
4. Pause/resume: load 0/5, start, pause after 2 edges, wait 10 cycles -> value stays 05, prescaler frozen. start -> 04 appears 2 edges later.
5. Priority/clamp: load 4'hA/4'hF with start in the same cycle -> 99 loaded, state IDLE. Start while at 00 -> ignored, running=0.
6. Reset mid-count: in RUN at 37, drive rst=0 for one edge -> 00, IDLE, running=0, no timeout pulse.
